// File: rtl/rf_wb_scoreboard_pkg.sv
// Shared widths and the write-back entry type for the register file write-back path.
package rf_wb_scoreboard_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     data_t;

   typedef struct packed {
      reg_addr_t rd;
      data_t     data;
   } wb_entry_t;
endpackage

// File: rtl/rf_busy_table.sv
// Busy-bit scoreboard for pending long-latency destinations; register 0 is never busy.
module rf_busy_table
   import rf_wb_scoreboard_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en,
   input  reg_addr_t           set_reg,
   input  logic                clr_en,
   input  reg_addr_t           clr_reg,
   input  reg_addr_t           rd_a,
   input  reg_addr_t           rd_b,
   input  reg_addr_t           rd_c,
   output logic                busy_a,
   output logic                busy_b,
   output logic                busy_c,
   output logic [NUM_REGS-1:0] busy_vec
);
   logic [NUM_REGS-1:0] busy, set_mask, clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[set_reg] = 1'b1;
      if (clr_en) clr_mask[clr_reg] = 1'b1;
      set_mask[0] = 1'b0;
   end

   // Set is applied after clear so a new issue wins over a same-cycle drain.
   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= (busy & ~clr_mask) | set_mask;
   end

   assign busy_a   = busy[rd_a];
   assign busy_b   = busy[rd_b];
   assign busy_c   = busy[rd_c];
   assign busy_vec = busy;
endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register file write-port arbiter: ALU stream always wins, one mul/div result is held
// until a free slot, with starvation bubble request and decode hazard stall.
module rf_wb_scoreboard
   import rf_wb_scoreboard_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_wb_valid,
   input  logic [4:0]        alu_wb_reg,
   input  logic [31:0]       alu_wb_data,
   input  logic              md_valid,
   input  logic [4:0]        md_reg,
   input  logic [31:0]       md_data,
   output logic              md_ready,
   input  logic              issue_valid,
   input  logic [4:0]        issue_reg,
   input  logic [4:0]        chk_rs,
   input  logic [4:0]        chk_rt,
   input  logic [4:0]        chk_rd,
   output logic              hazard_stall,
   output logic              wb_stall_req,
   output logic              reg_write,
   output logic [4:0]        write_reg,
   output logic [31:0]       write_data
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic                hold_valid;
   wb_entry_t           hold;
   logic [CNT_W-1:0]    starve_cnt;
   logic                drain, accept, set_en, hazard_raw;
   logic                busy_rs, busy_rt, busy_rd;
   logic [NUM_REGS-1:0] busy_vec;

   assign drain      = !rst && hold_valid && !alu_wb_valid;
   assign md_ready   = !rst && (!hold_valid || drain);
   assign accept     = md_valid && md_ready;
   assign hazard_raw = busy_rs || busy_rt || busy_rd || (issue_valid && busy_vec[issue_reg]);
   assign hazard_stall = !rst && hazard_raw;
   assign set_en     = !rst && issue_valid && (issue_reg != '0) && !hazard_raw;
   assign wb_stall_req = !rst && hold_valid && (starve_cnt == LIMIT);

   always_comb begin
      reg_write  = 1'b0;
      write_reg  = '0;
      write_data = '0;
      if (!rst) begin
         if (alu_wb_valid) begin
            reg_write  = 1'b1;
            write_reg  = alu_wb_reg;
            write_data = alu_wb_data;
         end else if (hold_valid) begin
            reg_write  = 1'b1;
            write_reg  = hold.rd;
            write_data = hold.data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold       <= '0;
      end else if (accept) begin
         hold_valid <= 1'b1;
         hold       <= '{rd: md_reg, data: md_data};
      end else if (drain) begin
         hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !hold_valid || drain) starve_cnt <= '0;
      else if (alu_wb_valid && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
   end

   rf_busy_table u_busy (
      .clk      (clk),
      .rst      (rst),
      .set_en   (set_en),
      .set_reg  (issue_reg),
      .clr_en   (drain),
      .clr_reg  (hold.rd),
      .rd_a     (chk_rs),
      .rd_b     (chk_rt),
      .rd_c     (chk_rd),
      .busy_a   (busy_rs),
      .busy_b   (busy_rt),
      .busy_c   (busy_rd),
      .busy_vec (busy_vec)
   );
endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard: reset, drain, contention, starvation, back-to-back, r0.
module tb_rf_wb_scoreboard;
   logic        clk = 1'b0;
   logic        rst;
   logic        alu_wb_valid;
   logic [4:0]  alu_wb_reg;
   logic [31:0] alu_wb_data;
   logic        md_valid;
   logic [4:0]  md_reg;
   logic [31:0] md_data;
   logic        md_ready;
   logic        issue_valid;
   logic [4:0]  issue_reg;
   logic [4:0]  chk_rs, chk_rt, chk_rd;
   logic        hazard_stall, wb_stall_req, reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rf_wb_scoreboard #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .alu_wb_valid(alu_wb_valid), .alu_wb_reg(alu_wb_reg), .alu_wb_data(alu_wb_data),
      .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
      .issue_valid(issue_valid), .issue_reg(issue_reg),
      .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd),
      .hazard_stall(hazard_stall), .wb_stall_req(wb_stall_req),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data)
   );

   // md payload must hold steady while stalled
   logic        md_wait_q = 1'b0;
   logic [36:0] md_pay_q;
   always @(posedge clk) begin
      if (md_wait_q && md_valid && !rst && {md_reg, md_data} != md_pay_q)
         $error("protocol violation: md payload changed while stalled");
      md_wait_q <= md_valid && !md_ready && !rst;
      md_pay_q  <= {md_reg, md_data};
   end

   task automatic idle();
      alu_wb_valid = 0; alu_wb_reg = 0; alu_wb_data = 0;
      md_valid = 0; md_reg = 0; md_data = 0;
      issue_valid = 0; issue_reg = 0;
      chk_rs = 0; chk_rt = 0; chk_rd = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1; idle(); step();
      md_valid = 1; md_reg = 5; md_data = 32'h5;
      #1;
      checks++;
      if ({md_ready, reg_write, hazard_stall, wb_stall_req} !== 4'b0) begin
         errors++; $display("FAIL reset_outputs got %b exp 0000", {md_ready, reg_write, hazard_stall, wb_stall_req});
      end
      rst = 0; idle(); step();
      // mid-operation: issue r5, accept its result, then reset
      issue_valid = 1; issue_reg = 5; step();
      idle(); md_valid = 1; md_reg = 5; md_data = 32'h5555; step();
      idle(); chk_rs = 5; #1;
      checks++;
      if (hazard_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", hazard_stall); end
      rst = 1; alu_wb_valid = 1; alu_wb_reg = 2; alu_wb_data = 32'h22; md_valid = 1; md_reg = 5; #1;
      checks++;
      if ({md_ready, reg_write, hazard_stall, wb_stall_req, write_reg} !== 9'b0 || write_data !== 32'h0) begin
         errors++; $display("FAIL rst_high_outputs got %b/%h exp 0/0",
                            {md_ready, reg_write, hazard_stall, wb_stall_req, write_reg}, write_data);
      end
      step(); rst = 0; idle(); chk_rs = 5; #1;
      checks++;
      if ({hazard_stall, reg_write, md_ready} !== 3'b001) begin
         errors++; $display("FAIL post_reset_state got %b exp 001", {hazard_stall, reg_write, md_ready});
      end
   endtask

   task automatic test_idle_drain();
      idle(); issue_valid = 1; issue_reg = 8; #1;
      checks++;
      if (hazard_stall !== 1'b0) begin errors++; $display("FAIL issue_r8_stall got %b exp 0", hazard_stall); end
      step(); idle(); chk_rs = 8; #1;
      checks++;
      if (hazard_stall !== 1'b1) begin errors++; $display("FAIL busy_r8 got %b exp 1", hazard_stall); end
      md_valid = 1; md_reg = 8; md_data = 32'h1234; #1;
      checks++;
      if ({md_ready, reg_write} !== 2'b10) begin errors++; $display("FAIL accept_r8 got %b exp 10", {md_ready, reg_write}); end
      step(); md_valid = 0; #1;
      checks++;
      if ({reg_write, write_reg, write_data, hazard_stall} !== {1'b1, 5'd8, 32'h1234, 1'b1}) begin
         errors++; $display("FAIL drain_r8 got %b %0d %h %b exp 1 8 1234 1", reg_write, write_reg, write_data, hazard_stall);
      end
      step(); #1;
      checks++;
      if ({hazard_stall, reg_write} !== 2'b00) begin errors++; $display("FAIL after_drain_r8 got %b exp 00", {hazard_stall, reg_write}); end
   endtask

   task automatic test_contention();
      idle(); issue_valid = 1; issue_reg = 8; step();
      idle(); md_valid = 1; md_reg = 8; md_data = 32'hAA; step();
      for (int i = 0; i < 2; i++) begin
         idle(); alu_wb_valid = 1; alu_wb_reg = 3; alu_wb_data = 32'h55; #1;
         checks++;
         if ({reg_write, write_reg, write_data, md_ready} !== {1'b1, 5'd3, 32'h55, 1'b0}) begin
            errors++; $display("FAIL contention_%0d got %b %0d %h rdy=%b exp 1 3 55 rdy=0", i, reg_write, write_reg, write_data, md_ready);
         end
         step();
      end
      idle(); #1;
      checks++;
      if ({reg_write, write_reg, write_data, md_ready} !== {1'b1, 5'd8, 32'hAA, 1'b1}) begin
         errors++; $display("FAIL contention_drain got %b %0d %h rdy=%b exp 1 8 aa rdy=1", reg_write, write_reg, write_data, md_ready);
      end
      step();
   endtask

   task automatic test_starvation();
      idle(); issue_valid = 1; issue_reg = 6; step();
      idle(); md_valid = 1; md_reg = 6; md_data = 32'h66; step();
      for (int i = 1; i <= 5; i++) begin
         idle(); alu_wb_valid = 1; alu_wb_reg = 1; alu_wb_data = 32'(i); #1;
         checks++;
         if (wb_stall_req !== (i == 5)) begin
            errors++; $display("FAIL starve_cycle_%0d got %b exp %b", i, wb_stall_req, (i == 5));
         end
         if (i < 5) step();
      end
      idle(); #1;
      checks++;
      if ({reg_write, write_reg, write_data, wb_stall_req} !== {1'b1, 5'd6, 32'h66, 1'b1}) begin
         errors++; $display("FAIL starve_bubble got %b %0d %h req=%b exp 1 6 66 req=1", reg_write, write_reg, write_data, wb_stall_req);
      end
      step(); #1;
      checks++;
      if ({wb_stall_req, reg_write} !== 2'b00) begin errors++; $display("FAIL starve_release got %b exp 00", {wb_stall_req, reg_write}); end
   endtask

   task automatic test_back_to_back();
      idle(); issue_valid = 1; issue_reg = 9; step();
      idle(); issue_valid = 1; issue_reg = 10; step();
      idle(); md_valid = 1; md_reg = 9; md_data = 32'h909; step();
      idle(); md_valid = 1; md_reg = 10; md_data = 32'hB10; #1;
      checks++;
      if ({md_ready, reg_write, write_reg, write_data} !== {1'b1, 1'b1, 5'd9, 32'h909}) begin
         errors++; $display("FAIL b2b_refill got rdy=%b %b %0d %h exp rdy=1 1 9 909", md_ready, reg_write, write_reg, write_data);
      end
      step(); idle(); chk_rs = 9; chk_rt = 10; #1;
      checks++;
      if ({reg_write, write_reg, write_data, hazard_stall} !== {1'b1, 5'd10, 32'hB10, 1'b1}) begin
         errors++; $display("FAIL b2b_r10 got %b %0d %h hz=%b exp 1 10 b10 hz=1", reg_write, write_reg, write_data, hazard_stall);
      end
      step(); #1;
      checks++;
      if ({hazard_stall, reg_write} !== 2'b00) begin errors++; $display("FAIL b2b_clear got %b exp 00", {hazard_stall, reg_write}); end
   endtask

   task automatic test_r0();
      idle(); issue_valid = 1; issue_reg = 0; #1;
      checks++;
      if (hazard_stall !== 1'b0) begin errors++; $display("FAIL r0_issue got %b exp 0", hazard_stall); end
      step(); idle(); chk_rs = 0; chk_rt = 0; chk_rd = 0; #1;
      checks++;
      if (hazard_stall !== 1'b0) begin errors++; $display("FAIL r0_busy got %b exp 0", hazard_stall); end
      // an ALU write to r0 still drives the port
      alu_wb_valid = 1; alu_wb_reg = 0; alu_wb_data = 32'hDEAD; #1;
      checks++;
      if ({reg_write, write_reg, write_data} !== {1'b1, 5'd0, 32'hDEAD}) begin
         errors++; $display("FAIL r0_write got %b %0d %h exp 1 0 dead", reg_write, write_reg, write_data);
      end
      step(); idle();
   endtask

   initial begin
      test_reset();
      test_idle_drain();
      test_contention();
      test_starvation();
      test_back_to_back();
      test_r0();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_wb_scoreboard.md
Name: rf_wb_scoreboard

Overview:
- Write-back controller for the 32x32 register file's single write port.
- Arbitrates between the in-order ALU/load write-back stream and a long-latency mul/div unit.
- Buffers one mul/div result in a holding register and tracks pending long-latency destinations in a busy-bit scoreboard.
- Produces the hazard stall used by decode.

Parameters:
- STARVE_LIMIT, 4: consecutive blocked cycles of a held mul/div result before a forced pipeline bubble is requested.
- CNT_W, 3: starvation counter width. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- alu_wb_valid  input  1  in-order pipeline write-back this cycle (cannot be stalled)
- alu_wb_reg  input  5  destination register
- alu_wb_data  input  32  write data
- md_valid  input  1  mul/div result offered
- md_reg  input  5  mul/div destination
- md_data  input  32  mul/div result
- md_ready  output  1  result accepted this cycle when md_valid && md_ready
- issue_valid  input  1  decode issuing a mul/div with destination issue_reg
- issue_reg  input  5  mul/div destination being issued
- chk_rs  input  5  decode source register 1
- chk_rt  input  5  decode source register 2
- chk_rd  input  5  decode destination register
- hazard_stall  output  1  decode must stall
- wb_stall_req  output  1  request a one-cycle write-back bubble
- reg_write  output  1  register file write enable
- write_reg  output  5  register file write address
- write_data  output  32  register file write data

Behaviour:
- State:
  - busy[31:1], one bit per register; register 0 is never busy.
  - hold_valid, hold_reg, hold_data.
  - starve_cnt (CNT_W bits).
- Reset (synchronous, rst high at posedge):
  - busy=0, hold_valid=0, starve_cnt=0.
  - While rst is high, all outputs are 0. This includes md_ready, so an in-flight md result offered during rst is dropped.
- Write-port arbitration (combinational):
  - alu_wb_valid=1: reg_write=1, write_reg=alu_wb_reg, write_data=alu_wb_data. ALU always wins.
  - Else hold_valid=1 (drain): reg_write=1, write_reg=hold_reg, write_data=hold_data.
  - Else reg_write=0 and write_reg/write_data=0.
  - Writes to register 0 pass through unchanged; the register file ignores them.
- Holding register:
  - md_ready = !hold_valid || drain. A same-cycle drain and refill is permitted.
  - On accept: hold_valid<=1, hold_reg<=md_reg, hold_data<=md_data.
  - On drain without accept: hold_valid<=0.
  - Result latency: an accepted result is written 1 cycle later at the earliest, i.e. the first cycle with alu_wb_valid=0.
- Starvation counter:
  - Increments each cycle with hold_valid && alu_wb_valid, saturating at STARVE_LIMIT.
  - Clears on drain or when hold is empty.
  - wb_stall_req = hold_valid && (starve_cnt == STARVE_LIMIT).
  - The pipeline responds by dropping alu_wb_valid for one cycle, which drains the hold.
- Scoreboard:
  - Set busy[issue_reg] on issue_valid && issue_reg!=0 && !hazard_stall.
  - Clear busy[hold_reg] on the drain cycle.
  - Same-cycle set and clear of the same register: set wins. It is a new issue, so this is legal only after the old result drains.
- Hazard stall:
  - hazard_stall = (busy[chk_rs] || busy[chk_rt] || busy[chk_rd] || (issue_valid && busy[issue_reg])), with index 0 ignored.
  - No bypass from the hold register. A register being drained this cycle still stalls; it is clear the next cycle.
  - The chk_rd term prevents WAW between ALU write-back and a pending mul/div result.
- Protocol violations (bench asserts them, RTL does not correct them):
  - alu_wb_valid to a busy register.
  - md result for a register not marked busy.
  - md_data/md_reg changing while md_valid && !md_ready.

Decomposition:
- Shared package constants: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
- Natural sub-module: rf_busy_table (32-bit busy vector with set/clear ports and three read ports).
- Arbitration, hold register and starvation counter remain in the top.

Test Plan:
- Reset mid-operation: issue r5, accept md result, assert rst -> next cycle busy=0, hold_valid=0; all outputs 0 during rst.
- Idle drain: issue r8 -> hazard_stall=1 for chk_rs=8. md_valid with r8/0x1234 and alu_wb_valid=0 -> next cycle reg_write=1, write_reg=8, write_data=0x1234. Cycle after that hazard_stall=0.
- Contention: hold r8/0xAA while alu_wb_valid=1 with r3/0x55 for 2 cycles -> write_reg=3 each cycle, md_ready=0. At alu_wb_valid=0 the hold drains r8/0xAA.
- Starvation: alu_wb_valid held high with hold_valid=1 -> wb_stall_req=1 after exactly 4 blocked cycles. Bubble cycle drains the hold, and wb_stall_req drops the next cycle.
- Back-to-back: hold r9 drains while md offers r10 the same cycle -> md_ready=1; r10 is written the next idle cycle.
- r0 handling: issue_reg=0 -> no busy bit set, hazard_stall=0 for chk_rs=0.
